misc_arb: RTL and testbench
===========================

# misc_arb

Round-robin arbiter and collector for the per-link miscellaneous packet FIFOs (SCSI inquiry records). It sits downstream of each link's misc FIFO wrapper. It grants one link at a time, pops a fixed-length burst of 256-bit words, and tags each word with its source link. The words are buffered in an output FIFO that feeds the PCIe DMA write path. Credit accounting ensures a granted burst always fits, so the misc FIFOs never see back-pressure mid-burst.

## Interface
Parameters:
- NUM_LINKS, 4: number of link misc FIFOs arbitrated.
- BURST_LEN, 2: 256-bit words popped per grant (one misc record).
- OUT_DEPTH, 16: output FIFO depth in words, power of 2, ≥ 2·BURST_LEN.
- TIMEOUT, 64: cycles allowed from first pop to last returned word.

Ports. One clock; reset is synchronous and active-low.
- iCLK, in, 1: clock (PCIe-side domain, same as the misc FIFO read side).
- iRST_N, in, 1: synchronous active-low reset.
- iLINK_EN, in, NUM_LINKS: per-link arbitration enable.
- iMISC_FIFO_RD_REQ, in, NUM_LINKS: link holds at least one complete record.
- iMISC_FIFO_DATA, in, NUM_LINKS×256: popped data per link.
- iMISC_FIFO_DATA_V, in, NUM_LINKS: popped-data valid per link.
- oMISC_ARB_GRANT, out, NUM_LINKS: one-hot pop strobe to the links.
- oDMA_DATA, out, 256: output word.
- oDMA_LINK, out, $clog2(NUM_LINKS): source link tag.
- oDMA_SOP, out, 1: first word of a burst.
- oDMA_EOP, out, 1: last word of a burst.
- oDMA_V, out, 1: output valid.
- iDMA_RDY, in, 1: DMA accepts; a transfer happens when oDMA_V and iDMA_RDY are both high.
- oPKT_CNT, out, 32: completed bursts, wraps at 2^32.
- oERR_TIMEOUT, out, 1: sticky; a burst timed out.
- oERR_STRAY, out, 1: sticky; DATA_V arrived from a link that was not granted.

## Operation
- FSM states: IDLE, POP, COLLECT.
- IDLE:
  - Eligible set = iMISC_FIFO_RD_REQ & iLINK_EN.
  - Selection is round-robin starting at the link after the last granted link (the pointer resets to NUM_LINKS-1, so link 0 has first priority).
  - A grant requires free credits ≥ BURST_LEN, where free = OUT_DEPTH − fifo_count − outstanding.
  - On select: latch the link index, set outstanding = BURST_LEN, then go to POP.
- POP:
  - oMISC_ARB_GRANT[sel] is high for exactly BURST_LEN consecutive cycles, then the FSM goes to COLLECT.
- COLLECT (data may also return while still in POP):
  - Only iMISC_FIFO_DATA_V[sel] is accepted.
  - Each accepted word is written to the output FIFO with tag sel. SOP is set on the first word of the burst; EOP on word BURST_LEN-1.
  - Each accepted word decrements outstanding.
  - When outstanding reaches 0: oPKT_CNT increments, the round-robin pointer becomes sel, and the FSM returns to IDLE.
- Timeout:
  - A counter starts at the first pop.
  - If it reaches TIMEOUT with outstanding ≠ 0: set oERR_TIMEOUT, clear outstanding, return to IDLE.
  - Words already written stay in the FIFO; the partial burst has no EOP.
  - oPKT_CNT does not increment.
- DATA_V from any link other than sel, or while in IDLE: the word is dropped and oERR_STRAY is set.
- A link whose iLINK_EN drops mid-burst still completes its burst.
- Output FIFO:
  - Show-ahead: oDMA_* reflect the head entry whenever the FIFO is non-empty.
  - Simultaneous write and read keep the count unchanged.
  - Overflow is impossible by construction; an assertion checks it.
- Reset:
  - All outputs are 0, the FIFO is emptied, outstanding is 0, the FSM is in IDLE, and the pointer is NUM_LINKS-1.
  - Reset applied mid-burst abandons the burst. Any DATA_V that follows reset is stray.
- Error flags clear only on reset.

## Timing
- A request seen in IDLE at cycle t produces the first grant at t+1, registered.
- Grants occupy t+1 .. t+BURST_LEN.
- Input-to-output latency: DATA_V at cycle c gives oDMA_V at c+1 when the FIFO was empty (one write register plus show-ahead).
- Back-to-back bursts: the next grant can come at the cycle after the last word is accepted. Per-burst overhead is 1 IDLE cycle.
- Credits use fifo_count registered at the current cycle; a read in the same cycle is not counted. This is conservative.
- oPKT_CNT updates the cycle after the EOP word is written.

## Structure
- Package misc_arb_pkg:
  - typedef arb_state_e {IDLE, POP, COLLECT};
  - typedef struct misc_arb_word_t {data[255:0], link, sop, eop};
  - constant MISC_WORD_W = 256.
- Sub-module misc_arb_ofifo: synchronous show-ahead FIFO of misc_arb_word_t, depth OUT_DEPTH. It exposes count, wr, rd, and the head entry. Pointers are $clog2(OUT_DEPTH)+1 bits wide, with the wrap bit used for full/empty.
- Top level: FSM, round-robin selector, credit counter, timeout counter, statistics.

## Test plan
- Single request: link 2 requests, RDY=1, the FIFO returns 2 words 3 cycles after each pop. Required: GRANT=4'b0100 for 2 cycles; oDMA_LINK=2 with SOP then EOP; oPKT_CNT=1.
- Fairness: all 4 links request continuously. Required grant order 0,1,2,3,0; each link gets 2 bursts in 8.
- Back-pressure: RDY=0 with OUT_DEPTH=16. Exactly 8 bursts (16 words) are granted, then no grant until RDY=1. Required: no overflow, no lost words.
- Timeout: link 1 is granted but returns only 1 word. Required: oERR_TIMEOUT=1 at first pop + 64; FSM back in IDLE; oPKT_CNT unchanged; the next request is served.
- Stray: DATA_V[3] pulses while link 0 is granted. Required: the word is dropped, oERR_STRAY=1, and link 0's burst is intact.
- Reset mid-burst: iRST_N=0 during POP. Required: all outputs are 0 on the next edge, the FIFO is empty, and after release link 0 has first priority.

Source files
------------

// File: rtl/misc_arb_pkg.sv
// Shared types for the misc-packet arbiter: FSM states and the tagged output word.
package misc_arb_pkg;

  localparam int MISC_WORD_W = 256;
  localparam int LINK_TAG_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    COLLECT
  } arb_state_e;

  typedef struct packed {
    logic [MISC_WORD_W-1:0] data;
    logic [LINK_TAG_W-1:0]  link;
    logic                   sop;
    logic                   eop;
  } misc_arb_word_t;

endpackage

// File: rtl/misc_arb_ofifo.sv
// Show-ahead output FIFO of tagged misc words; head valid whenever not empty.
// Zero-cycle read latency; the arbiter's credit scheme guarantees it never overflows.
module misc_arb_ofifo
  import misc_arb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr,
  input  misc_arb_word_t         wdata,
  input  logic                   rd,
  output misc_arb_word_t         head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  misc_arb_word_t mem [DEPTH];
  logic [AW:0]    wp;
  logic [AW:0]    rp;
  logic           full;

  assign empty = (wp == rp);
  assign full  = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
  assign count = wp - rp;
  assign head  = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd && !empty) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp[AW-1:0]] <= wdata;
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(wr && full));

endmodule

// File: rtl/misc_arb.sv
// Round-robin arbiter pulling fixed-length bursts from per-link misc FIFOs into a tagged output FIFO.
// Grant one cycle after request; bursts only start when the output FIFO has room for the whole burst.
module misc_arb
  import misc_arb_pkg::*;
#(
  parameter int NUM_LINKS = 4,
  parameter int BURST_LEN = 2,
  parameter int OUT_DEPTH = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                             iCLK,
  input  logic                             iRST_N,
  input  logic [NUM_LINKS-1:0]             iLINK_EN,
  input  logic [NUM_LINKS-1:0]             iMISC_FIFO_RD_REQ,
  input  logic [NUM_LINKS*MISC_WORD_W-1:0] iMISC_FIFO_DATA,
  input  logic [NUM_LINKS-1:0]             iMISC_FIFO_DATA_V,
  output logic [NUM_LINKS-1:0]             oMISC_ARB_GRANT,
  output logic [MISC_WORD_W-1:0]           oDMA_DATA,
  output logic [$clog2(NUM_LINKS)-1:0]     oDMA_LINK,
  output logic                             oDMA_SOP,
  output logic                             oDMA_EOP,
  output logic                             oDMA_V,
  input  logic                             iDMA_RDY,
  output logic [31:0]                      oPKT_CNT,
  output logic                             oERR_TIMEOUT,
  output logic                             oERR_STRAY
);

  localparam int LW = $clog2(NUM_LINKS);
  localparam int CW = $clog2(OUT_DEPTH) + 1;
  localparam int OW = $clog2(BURST_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  arb_state_e     state;
  logic [LW-1:0]  sel;
  logic [LW-1:0]  ptr;
  logic [OW-1:0]  outstanding;
  logic [OW-1:0]  pop_cnt;
  logic [TW-1:0]  tmo_cnt;

  logic [NUM_LINKS-1:0] eligible;
  logic [NUM_LINKS-1:0] acc_mask;
  logic [LW-1:0]        pick;
  logic                 found;
  logic                 free_ok;
  logic                 accept;
  logic                 stray_any;

  misc_arb_word_t wdata;
  misc_arb_word_t head;
  logic [CW-1:0]  fifo_count;
  logic           fifo_empty;
  logic           fifo_rd;
  logic           unused_link_hi;

  assign eligible = iMISC_FIFO_RD_REQ & iLINK_EN;

  // Search starts one past the last completed link so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= NUM_LINKS; i++) begin
      if (!found && eligible[(int'(ptr) + i) % NUM_LINKS]) begin
        found = 1'b1;
        pick  = LW'((int'(ptr) + i) % NUM_LINKS);
      end
    end
  end

  // Registered count only: a same-cycle DMA read is ignored, which errs on the safe side.
  always_comb free_ok = (OUT_DEPTH - int'(fifo_count) - int'(outstanding)) >= BURST_LEN;

  assign acc_mask  = (state != IDLE) ? (NUM_LINKS'(1) << sel) : '0;
  assign accept    = |(iMISC_FIFO_DATA_V & acc_mask);
  assign stray_any = |(iMISC_FIFO_DATA_V & ~acc_mask);

  always_comb begin
    wdata      = '0;
    wdata.data = iMISC_FIFO_DATA[int'(sel)*MISC_WORD_W +: MISC_WORD_W];
    wdata.link = LINK_TAG_W'(sel);
    wdata.sop  = (outstanding == OW'(BURST_LEN));
    wdata.eop  = (outstanding == OW'(1));
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state           <= IDLE;
      sel             <= '0;
      ptr             <= LW'(NUM_LINKS - 1);
      outstanding     <= '0;
      pop_cnt         <= '0;
      tmo_cnt         <= '0;
      oMISC_ARB_GRANT <= '0;
      oPKT_CNT        <= '0;
      oERR_TIMEOUT    <= 1'b0;
      oERR_STRAY      <= 1'b0;
    end else begin
      if (stray_any) oERR_STRAY <= 1'b1;
      case (state)
        IDLE: begin
          if (found && free_ok) begin
            sel             <= pick;
            outstanding     <= OW'(BURST_LEN);
            oMISC_ARB_GRANT <= NUM_LINKS'(1) << pick;
            pop_cnt         <= OW'(1);
            tmo_cnt         <= '0;
            state           <= POP;
          end
        end
        POP, COLLECT: begin
          if (state == POP) begin
            if (pop_cnt == OW'(BURST_LEN)) begin
              oMISC_ARB_GRANT <= '0;
              state           <= COLLECT;
            end else begin
              pop_cnt <= pop_cnt + 1'b1;
            end
          end
          if (accept) outstanding <= outstanding - 1'b1;
          tmo_cnt <= tmo_cnt + 1'b1;
          if (accept && outstanding == OW'(1)) begin
            oPKT_CNT        <= oPKT_CNT + 32'd1;
            ptr             <= sel;
            oMISC_ARB_GRANT <= '0;
            state           <= IDLE;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            // Partial words stay queued without EOP; the DMA side sees a truncated record.
            oERR_TIMEOUT    <= 1'b1;
            outstanding     <= '0;
            oMISC_ARB_GRANT <= '0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fifo_rd = oDMA_V && iDMA_RDY;

  misc_arb_ofifo #(.DEPTH(OUT_DEPTH)) u_ofifo (
    .clk   (iCLK),
    .rst_n (iRST_N),
    .wr    (accept),
    .wdata (wdata),
    .rd    (fifo_rd),
    .head  (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign oDMA_V         = ~fifo_empty;
  assign oDMA_DATA      = fifo_empty ? '0 : head.data;
  assign oDMA_LINK      = fifo_empty ? '0 : head.link[LW-1:0];
  assign oDMA_SOP       = ~fifo_empty & head.sop;
  assign oDMA_EOP       = ~fifo_empty & head.eop;
  assign unused_link_hi = ^head.link;

endmodule

// File: tb/tb_misc_arb.sv
// Bench for misc_arb: link responder model feeds a scoreboard; a DMA monitor pops and compares.
module tb_misc_arb;
  import misc_arb_pkg::*;

  localparam int NL = 4;
  localparam int BL = 2;
  localparam int OD = 16;
  localparam int TO = 64;

  typedef struct packed {
    logic [255:0] data;
    logic [1:0]   link;
    logic         sop;
    logic         eop;
  } exp_t;

  logic            iCLK = 1'b0;
  logic            iRST_N = 1'b0;
  logic [NL-1:0]   iLINK_EN = '1;
  logic [NL-1:0]   iMISC_FIFO_RD_REQ = '0;
  logic [NL*256-1:0] iMISC_FIFO_DATA = '0;
  logic [NL-1:0]   iMISC_FIFO_DATA_V = '0;
  logic [NL-1:0]   oMISC_ARB_GRANT;
  logic [255:0]    oDMA_DATA;
  logic [1:0]      oDMA_LINK;
  logic            oDMA_SOP;
  logic            oDMA_EOP;
  logic            oDMA_V;
  logic            iDMA_RDY = 1'b1;
  logic [31:0]     oPKT_CNT;
  logic            oERR_TIMEOUT;
  logic            oERR_STRAY;

  misc_arb #(.NUM_LINKS(NL), .BURST_LEN(BL), .OUT_DEPTH(OD), .TIMEOUT(TO)) dut (
    .iCLK              (iCLK),
    .iRST_N            (iRST_N),
    .iLINK_EN          (iLINK_EN),
    .iMISC_FIFO_RD_REQ (iMISC_FIFO_RD_REQ),
    .iMISC_FIFO_DATA   (iMISC_FIFO_DATA),
    .iMISC_FIFO_DATA_V (iMISC_FIFO_DATA_V),
    .oMISC_ARB_GRANT   (oMISC_ARB_GRANT),
    .oDMA_DATA         (oDMA_DATA),
    .oDMA_LINK         (oDMA_LINK),
    .oDMA_SOP          (oDMA_SOP),
    .oDMA_EOP          (oDMA_EOP),
    .oDMA_V            (oDMA_V),
    .iDMA_RDY          (iDMA_RDY),
    .oPKT_CNT          (oPKT_CNT),
    .oERR_TIMEOUT      (oERR_TIMEOUT),
    .oERR_STRAY        (oERR_STRAY)
  );

  always #5 iCLK = ~iCLK;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   serial = 1;
  int   short_link = -1;
  logic stray_req = 1'b0;
  exp_t exp_q[$];
  int   g_link[$];
  int   g_len[$];
  int   g_cyc[$];
  logic [NL-1:0] g_val[$];
  logic [2:0] pipe [NL];
  int   idx [NL];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic int enc(input logic [NL-1:0] g);
    for (int i = 0; i < NL; i++) if (g[i]) return i;
    return -1;
  endfunction

  function automatic logic pipe_busy();
    for (int i = 0; i < NL; i++) if (pipe[i] != 3'b000) return 1'b1;
    return 1'b0;
  endfunction

  initial forever begin
    @(posedge iCLK);
    cyc++;
  end

  // Grant monitor: logs each grant episode (link, one-hot value, start cycle, length).
  initial begin
    logic [NL-1:0] g;
    logic [NL-1:0] pg;
    int len;
    pg = '0;
    len = 0;
    forever begin
      @(negedge iCLK);
      g = oMISC_ARB_GRANT;
      if (iRST_N) begin
        if (g != '0 && pg == '0) begin
          g_link.push_back(enc(g));
          g_val.push_back(g);
          g_cyc.push_back(cyc);
          len = 1;
          check("grant_onehot", $countones(g), 1);
        end else if (g != '0) begin
          len++;
        end
        if (g == '0 && pg != '0) g_len.push_back(len);
        pg = g;
      end else begin
        pg = '0;
      end
    end
  end

  // Link model: each pop returns one word three cycles later; expectations queued as words are sent.
  initial begin
    logic [NL-1:0] dv;
    logic [NL-1:0] g;
    logic [NL-1:0] pg;
    logic [NL*256-1:0] dat;
    logic [255:0] w;
    logic o;
    pg = '0;
    for (int l = 0; l < NL; l++) begin
      pipe[l] = '0;
      idx[l] = 0;
    end
    forever begin
      @(negedge iCLK);
      g = oMISC_ARB_GRANT;
      dv = '0;
      dat = '0;
      if (!iRST_N) begin
        for (int l = 0; l < NL; l++) begin
          pipe[l] = '0;
          idx[l] = 0;
        end
        pg = '0;
      end else begin
        for (int l = 0; l < NL; l++) begin
          o = pipe[l][2];
          pipe[l] = {pipe[l][1:0], g[l] && !(l == short_link && pg[l])};
          if (o) begin
            w = (256'(l) << 200) | 256'(serial);
            serial++;
            dv[l] = 1'b1;
            dat[l*256 +: 256] = w;
            exp_q.push_back({w, 2'(l), (idx[l] == 0), (idx[l] == BL - 1)});
            idx[l] = (idx[l] + 1) % BL;
          end
        end
        pg = g;
        if (stray_req) begin
          dv[3] = 1'b1;
          dat[3*256 +: 256] = {8{32'hDEAD_BEEF}};
          stray_req = 1'b0;
        end
      end
      iMISC_FIFO_DATA_V = dv;
      iMISC_FIFO_DATA = dat;
    end
  end

  // DMA monitor: every accepted output word must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge iCLK);
      if (iRST_N && oDMA_V && iDMA_RDY) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL dma_word: unexpected word link=%0d data=%h", oDMA_LINK, oDMA_DATA);
        end else begin
          e = exp_q.pop_front();
          if ({oDMA_DATA, oDMA_LINK, oDMA_SOP, oDMA_EOP} !== e) begin
            miscompares++;
            $display("FAIL dma_word: got link=%0d sop=%0b eop=%0b data=%h, expected link=%0d sop=%0b eop=%0b data=%h",
                     oDMA_LINK, oDMA_SOP, oDMA_EOP, oDMA_DATA, e.link, e.sop, e.eop, e.data);
          end
        end
      end
    end
  end

  task automatic set_rdy(input logic v);
    @(posedge iCLK);
    #1 iDMA_RDY = v;
  endtask

  task automatic do_reset();
    @(posedge iCLK);
    #1 iRST_N = 1'b0;
    repeat (2) @(posedge iCLK);
    #1;
    exp_q.delete();
    g_link.delete();
    g_len.delete();
    g_cyc.delete();
    g_val.delete();
    short_link = -1;
    iRST_N = 1'b1;
  endtask

  task automatic wait_grants(input int n, input string name);
    int k = 0;
    while (g_link.size() < n && k < 300) begin
      @(negedge iCLK);
      k++;
    end
    check(name, g_link.size(), n);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (!(exp_q.size() == 0 && !oDMA_V && oMISC_ARB_GRANT == '0 && !pipe_busy()) && k < 400) begin
      @(negedge iCLK);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, oMISC_ARB_GRANT, 0);
    check({tag, "_dma_v"}, oDMA_V, 0);
    check({tag, "_dma_data"}, oDMA_DATA[63:0] | oDMA_DATA[255:192], 0);
    check({tag, "_dma_tag"}, {oDMA_LINK, oDMA_SOP, oDMA_EOP}, 0);
    check({tag, "_pkt_cnt"}, oPKT_CNT, 0);
    check({tag, "_errs"}, {oERR_TIMEOUT, oERR_STRAY}, 0);
  endtask

  initial begin
    int k;
    int t_err;

    // Reset state
    repeat (3) @(negedge iCLK);
    check_all_zero("reset");
    @(posedge iCLK);
    #1 iRST_N = 1'b1;

    // Single request from link 2
    @(negedge iCLK);
    iMISC_FIFO_RD_REQ = 4'b0100;
    wait_grants(1, "single_grant_seen");
    iMISC_FIFO_RD_REQ = '0;
    drain("single_drain");
    repeat (2) @(negedge iCLK);
    check("single_link", g_link[0], 2);
    check("single_grant_val", g_val[0], 4'b0100);
    check("single_grant_len", g_len[0], BL);
    check("single_pkt_cnt", oPKT_CNT, 1);

    // Fairness: all links request continuously
    do_reset();
    iMISC_FIFO_RD_REQ = 4'b1111;
    wait_grants(8, "fair_grants_seen");
    iMISC_FIFO_RD_REQ = '0;
    drain("fair_drain");
    repeat (2) @(negedge iCLK);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fair_order_%0d", i), g_link[i], i % NL);
      check($sformatf("fair_len_%0d", i), g_len[i], BL);
    end
    check("fair_pkt_cnt", oPKT_CNT, 8);

    // Back-pressure: output stalled, credits must stop grants at 16 words
    do_reset();
    set_rdy(1'b0);
    iMISC_FIFO_RD_REQ = 4'b1111;
    repeat (200) @(negedge iCLK);
    check("bp_grant_count", g_link.size(), OD / BL);
    check("bp_words_sent", exp_q.size(), OD);
    check("bp_dma_v", oDMA_V, 1);
    check("bp_pkt_cnt", oPKT_CNT, OD / BL);
    iMISC_FIFO_RD_REQ = '0;
    set_rdy(1'b1);
    drain("bp_drain");

    // Timeout: link 1 returns only the first word
    do_reset();
    short_link = 1;
    iMISC_FIFO_RD_REQ = 4'b0010;
    wait_grants(1, "tmo_grant_seen");
    iMISC_FIFO_RD_REQ = '0;
    check("tmo_err_early", oERR_TIMEOUT, 0);
    k = 0;
    while (!oERR_TIMEOUT && k < 200) begin
      @(negedge iCLK);
      k++;
    end
    t_err = cyc;
    check("tmo_cycle", t_err - g_cyc[0], TO);
    check("tmo_pkt_cnt", oPKT_CNT, 0);
    drain("tmo_partial_drain");
    short_link = -1;
    idx[1] = 0;
    iMISC_FIFO_RD_REQ = 4'b0100;
    wait_grants(2, "tmo_next_grant");
    iMISC_FIFO_RD_REQ = '0;
    drain("tmo_next_drain");
    repeat (2) @(negedge iCLK);
    check("tmo_next_link", g_link[1], 2);
    check("tmo_next_pkt_cnt", oPKT_CNT, 1);
    check("tmo_err_sticky", oERR_TIMEOUT, 1);

    // Stray DATA_V on link 3 while link 0 is granted
    do_reset();
    @(negedge iCLK);
    check("stray_err_pre", oERR_STRAY, 0);
    iMISC_FIFO_RD_REQ = 4'b0001;
    wait_grants(1, "stray_grant_seen");
    stray_req = 1'b1;
    iMISC_FIFO_RD_REQ = '0;
    drain("stray_drain");
    repeat (2) @(negedge iCLK);
    check("stray_err", oERR_STRAY, 1);
    check("stray_tmo_clear", oERR_TIMEOUT, 0);
    check("stray_pkt_cnt", oPKT_CNT, 1);

    // Reset during POP with words sitting in the output FIFO
    do_reset();
    set_rdy(1'b0);
    iMISC_FIFO_RD_REQ = 4'b0001;
    wait_grants(1, "rst_first_grant");
    iMISC_FIFO_RD_REQ = '0;
    k = 0;
    while (oPKT_CNT != 1 && k < 50) begin
      @(negedge iCLK);
      k++;
    end
    check("rst_pre_pkt_cnt", oPKT_CNT, 1);
    check("rst_pre_dma_v", oDMA_V, 1);
    iMISC_FIFO_RD_REQ = 4'b0010;
    wait_grants(2, "rst_second_grant");
    iMISC_FIFO_RD_REQ = '0;
    iRST_N = 1'b0;
    @(negedge iCLK);
    check_all_zero("rst_mid");
    @(posedge iCLK);
    #1;
    exp_q.delete();
    g_link.delete();
    g_len.delete();
    g_cyc.delete();
    g_val.delete();
    iDMA_RDY = 1'b1;
    iRST_N = 1'b1;
    @(negedge iCLK);
    iMISC_FIFO_RD_REQ = 4'b0011;
    wait_grants(1, "rst_after_grant");
    iMISC_FIFO_RD_REQ = '0;
    check("rst_after_first_link", g_link[0], 0);
    drain("rst_after_drain");
    check("rst_after_stray", oERR_STRAY, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

endmodule
